// File: rtl/disp_vramrd.sv
// ----------------------------------------------------------------------------
// disp_vramrd -- VRAM read master for the XGA display path
//
// Fetches one frame of 16-bit pixels (HSIZE x VSIZE) from VRAM as 128-byte
// AXI4 INCR read bursts (16 beats x 64 bits). Every accepted read beat is
// forwarded combinationally into the display FIFO. A frame is kicked off by a
// frame-start level pulse from the pixel-clock domain, qualified by the
// display-enable level; both are resynchronised into the AXI clock domain.
//
// Exactly one burst is in flight at a time. A new address phase is only
// issued once the FIFO reports room for a whole burst, so RREADY can be held
// high for the entire data phase without ever overflowing the FIFO.
//
// Ports
//   i_clk      in   1  AXI/VRAM clock (only clock)
//   i_rst_n    in   1  asynchronous active-low reset (shared with interconnect)
//   AXISTART   in   1  frame-start level pulse, asynchronous to i_clk
//   DISPON     in   1  display enable level, asynchronous to i_clk
//   VRAMADR    in  32  frame base byte address (128-byte aligned)
//   FIFOREADY  in   1  FIFO has >= 16 free 64-bit entries
//   FIFOWR     out  1  FIFO write strobe
//   FIFOIN     out 64  FIFO write data
//   ARADDR     out 32  AXI read address
//   ARLEN/ARSIZE/ARBURST/ARCACHE/ARPROT/ARID  out  constant AXI fields
//   ARVALID    out  1  AXI read address valid
//   ARREADY    in   1  AXI read address ready
//   RDATA      in  64  AXI read data
//   RRESP      in   2  AXI read response
//   RLAST      in   1  AXI last beat of burst
//   RVALID     in   1  AXI read data valid
//   RREADY     out  1  AXI read data ready
//   RDERR      out  1  sticky: a SLVERR/DECERR beat was seen this frame
// ----------------------------------------------------------------------------
module disp_vramrd #(
    parameter int HSIZE  = 1024,
    parameter int VSIZE  = 768,
    parameter int BURSTS = HSIZE * VSIZE * 2 / 128
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        AXISTART,
    input  logic        DISPON,
    input  logic [31:0] VRAMADR,
    input  logic        FIFOREADY,
    output logic        FIFOWR,
    output logic [63:0] FIFOIN,
    output logic [31:0] ARADDR,
    output logic [7:0]  ARLEN,
    output logic [2:0]  ARSIZE,
    output logic [1:0]  ARBURST,
    output logic [3:0]  ARCACHE,
    output logic [2:0]  ARPROT,
    output logic        ARID,
    output logic        ARVALID,
    input  logic        ARREADY,
    input  logic [63:0] RDATA,
    input  logic [1:0]  RRESP,
    input  logic        RLAST,
    input  logic        RVALID,
    output logic        RREADY,
    output logic        RDERR
);

    // Index of the final burst of a frame, in counter width.
    localparam logic [13:0] LAST_BURST = 14'(BURSTS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAITF = 2'd1,
        S_ADDR  = 2'd2,
        S_DATA  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // Clock-domain crossing flops
    logic        r_start_m;
    logic        r_start_s;
    logic        r_start_d;
    logic        r_start_p;
    logic        r_dispon_m;
    logic        r_dispon_s;

    // Frame sequencing
    state_t      r_state;
    logic [13:0] r_cnt;
    logic [31:0] r_base;
    logic        r_restart;
    logic        r_rderr;

    // Registered AXI outputs
    logic        r_arvalid;
    logic        r_rready;
    logic [31:0] r_araddr;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic        w_beat;
    logic        w_last_beat;
    logic        w_restart;
    logic [31:0] w_burst_ofs;
    logic [31:0] w_next_addr;
    logic        w_unused;

    assign w_beat      = RVALID & r_rready;
    assign w_last_beat = w_beat & RLAST;
    // A start pulse coinciding with the last beat must not be lost.
    assign w_restart   = r_restart | r_start_p;
    assign w_burst_ofs = {11'd0, r_cnt, 7'd0};
    assign w_next_addr = r_base + w_burst_ofs;
    // Only RRESP[1] distinguishes an error response (SLVERR/DECERR).
    assign w_unused    = RRESP[0];

    // ------------------------------------------------------------------
    // Synchronisers: two flops per level, plus a third flop on the start
    // level so its rising edge becomes a single registered pulse.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_start_m  <= 1'b0;
            r_start_s  <= 1'b0;
            r_start_d  <= 1'b0;
            r_start_p  <= 1'b0;
            r_dispon_m <= 1'b0;
            r_dispon_s <= 1'b0;
        end else begin
            r_start_m  <= AXISTART;
            r_start_s  <= r_start_m;
            r_start_d  <= r_start_s;
            r_start_p  <= r_start_s & ~r_start_d;
            r_dispon_m <= DISPON;
            r_dispon_s <= r_dispon_m;
        end
    end

    // ------------------------------------------------------------------
    // Burst sequencer
    //   IDLE  : wait for a qualified frame start
    //   WAITF : wait until the FIFO can absorb a whole burst
    //   ADDR  : present ARADDR until the address handshake
    //   DATA  : accept the 16 beats of the outstanding burst
    // A start pulse outside IDLE is remembered in r_restart and honoured
    // at the end of the outstanding burst, so no AXI transfer is cut short.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_base    <= '0;
            r_restart <= 1'b0;
            r_rderr   <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_araddr  <= '0;
        end else begin
            // Error capture first; a frame restart later in this block
            // overrides it with a clear.
            if (w_beat && RRESP[1]) begin
                r_rderr <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (r_start_p && r_dispon_s) begin
                        r_base    <= VRAMADR;
                        r_cnt     <= '0;
                        r_rderr   <= 1'b0;
                        r_restart <= 1'b0;
                        r_state   <= S_WAITF;
                    end
                end

                S_WAITF: begin
                    if (r_start_p) begin
                        // Nothing outstanding: rewind to the new frame at once.
                        r_base    <= VRAMADR;
                        r_cnt     <= '0;
                        r_rderr   <= 1'b0;
                        r_restart <= 1'b0;
                    end else if (FIFOREADY) begin
                        r_araddr  <= w_next_addr;
                        r_arvalid <= 1'b1;
                        r_state   <= S_ADDR;
                    end
                end

                S_ADDR: begin
                    if (r_start_p) begin
                        r_restart <= 1'b1;
                    end
                    // ARVALID/ARADDR stay put until the slave takes them.
                    if (ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (r_start_p) begin
                        r_restart <= 1'b1;
                    end
                    if (w_last_beat) begin
                        r_rready <= 1'b0;
                        if (w_restart) begin
                            r_cnt     <= '0;
                            r_base    <= VRAMADR;
                            r_restart <= 1'b0;
                            r_rderr   <= 1'b0;
                            r_state   <= r_dispon_s ? S_WAITF : S_IDLE;
                        end else if (r_cnt == LAST_BURST) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt   <= r_cnt + 14'd1;
                            r_state <= S_WAITF;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // FIFO space was checked before the address phase, so each accepted
    // beat goes straight through; data is zeroed outside a beat.
    assign FIFOWR  = w_beat;
    assign FIFOIN  = w_beat ? RDATA : 64'd0;

    assign ARADDR  = r_araddr;
    assign ARVALID = r_arvalid;
    assign RREADY  = r_rready;
    assign RDERR   = r_rderr;

    // 16 beats x 8 bytes, incrementing, bufferable/modifiable, data access.
    assign ARLEN   = 8'd15;
    assign ARSIZE  = 3'b011;
    assign ARBURST = 2'b01;
    assign ARCACHE = 4'b0011;
    assign ARPROT  = 3'b000;
    assign ARID    = 1'b0;

endmodule

// File: tb/tb_disp_vramrd.sv
// ----------------------------------------------------------------------------
// tb_disp_vramrd -- self-checking bench for disp_vramrd
//
// A small AXI read slave answers each address with 16 beats whose data is a
// function of the beat address. At every address handshake the bench checks
// ARADDR against its own frame model and pushes the 16 expected FIFO words to
// a queue; each FIFOWR pops and compares one word. The frame is shrunk to
// 128 bursts so several frames fit in a short run.
// ----------------------------------------------------------------------------
module tb_disp_vramrd;

    localparam int HS = 256;
    localparam int VS = 32;
    localparam int NB = HS * VS * 2 / 128;   // 128 bursts per frame

    logic        clk;
    logic        rst_n;
    logic        AXISTART;
    logic        DISPON;
    logic [31:0] VRAMADR;
    logic        FIFOREADY;
    logic        FIFOWR;
    logic [63:0] FIFOIN;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic [3:0]  ARCACHE;
    logic [2:0]  ARPROT;
    logic        ARID;
    logic        ARVALID;
    logic        ARREADY;
    logic [63:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;
    logic        RDERR;

    disp_vramrd #(
        .HSIZE (HS),
        .VSIZE (VS)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .AXISTART  (AXISTART),
        .DISPON    (DISPON),
        .VRAMADR   (VRAMADR),
        .FIFOREADY (FIFOREADY),
        .FIFOWR    (FIFOWR),
        .FIFOIN    (FIFOIN),
        .ARADDR    (ARADDR),
        .ARLEN     (ARLEN),
        .ARSIZE    (ARSIZE),
        .ARBURST   (ARBURST),
        .ARCACHE   (ARCACHE),
        .ARPROT    (ARPROT),
        .ARID      (ARID),
        .ARVALID   (ARVALID),
        .ARREADY   (ARREADY),
        .RDATA     (RDATA),
        .RRESP     (RRESP),
        .RLAST     (RLAST),
        .RVALID    (RVALID),
        .RREADY    (RREADY),
        .RDERR     (RDERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bookkeeping
    int          n_chk  = 0;
    int          n_fail = 0;
    int          fire_cnt = 0;
    int          wr_cnt   = 0;
    logic [31:0] last_addr = '0;
    int          arv_len = 0;

    // Requests from the main sequence to the slave/model process
    int          ar_stall = 0;
    int          err_req  = 0;
    int          base_req = 0;
    logic [31:0] new_base = '0;

    // Slave/model state
    logic [63:0] exp_q[$];
    logic [31:0] pend_q[$];
    int          err_served = 0;
    int          base_ack   = 0;
    logic [31:0] exp_base   = '0;
    int          exp_idx    = 0;
    int          beat       = 0;
    int          arv_cnt    = 0;
    logic [31:0] hold_addr  = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] beat_data(input logic [31:0] a, input int i);
        logic [31:0] x;
        x = a + 32'(i * 8);
        return {x ^ 32'hA5A5_0000, ~x};
    endfunction

    // ------------------------------------------------------------------
    // AXI slave, frame model and FIFO scoreboard.
    // Observes at the falling edge, drives #1 after the rising edge.
    // ------------------------------------------------------------------
    initial begin : axi_slave
        logic        ar_fire;
        logic        r_fire;
        logic [63:0] e;
        logic [31:0] exp_addr;
        ARREADY = 1'b0;
        RVALID  = 1'b0;
        RDATA   = '0;
        RRESP   = 2'b00;
        RLAST   = 1'b0;
        forever begin
            @(negedge clk);
            ar_fire = ARVALID && ARREADY;
            r_fire  = RVALID && RREADY;
            if (!rst_n) begin
                exp_q.delete();
                pend_q.delete();
                beat    = 0;
                arv_cnt = 0;
            end else begin
                if (ARVALID && arv_cnt > 1)
                    check("araddr_hold", 64'(ARADDR), 64'(hold_addr));
                if (FIFOWR) begin
                    wr_cnt++;
                    check("fifo_expected", 64'(exp_q.size() > 0), 64'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("fifoin", FIFOIN, e);
                    end
                end
                if (ar_fire) begin
                    if (base_req != base_ack) begin
                        exp_base = new_base;
                        exp_idx  = 0;
                        base_ack = base_req;
                    end
                    exp_addr = exp_base + 32'(exp_idx) * 32'd128;
                    check("burst_complete", 64'(exp_q.size()), 64'd0);
                    check("one_outstanding", 64'(pend_q.size()), 64'd0);
                    check("araddr", 64'(ARADDR), 64'(exp_addr));
                    exp_idx++;
                    fire_cnt++;
                    last_addr = ARADDR;
                    arv_len   = arv_cnt;
                    arv_cnt   = 0;
                    for (int i = 0; i < 16; i++) exp_q.push_back(beat_data(ARADDR, i));
                    pend_q.push_back(ARADDR);
                end
                if (r_fire) begin
                    if (RRESP == 2'b10) err_served++;
                    beat++;
                    if (beat == 16) begin
                        beat = 0;
                        void'(pend_q.pop_front());
                    end
                end
            end
            @(posedge clk);
            #1;
            if (!rst_n) begin
                ARREADY = 1'b0;
                RVALID  = 1'b0;
                RLAST   = 1'b0;
                RRESP   = 2'b00;
                RDATA   = '0;
                arv_cnt = 0;
            end else begin
                if (arv_cnt > 0)
                    check("arvalid_held", 64'(ARVALID), 64'd1);
                if (ARVALID) begin
                    arv_cnt++;
                    if (arv_cnt == 1) hold_addr = ARADDR;
                    ARREADY = (arv_cnt > ar_stall);
                end else begin
                    arv_cnt = 0;
                    ARREADY = 1'b0;
                end
                if (pend_q.size() > 0) begin
                    RVALID = 1'b1;
                    RDATA  = beat_data(pend_q[0], beat);
                    RLAST  = (beat == 15);
                    RRESP  = (err_req != err_served && beat == 5) ? 2'b10 : 2'b00;
                end else begin
                    RVALID = 1'b0;
                    RDATA  = '0;
                    RLAST  = 1'b0;
                    RRESP  = 2'b00;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequence helpers
    // ------------------------------------------------------------------
    task automatic open_frame(input logic [31:0] base);
        VRAMADR  = base;
        new_base = base;
        base_req++;
    endtask

    task automatic pulse_start(input int n);
        AXISTART = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        AXISTART = 1'b0;
    endtask

    task automatic wait_fires(input int target, input int budget, input string tag);
        int c;
        c = 0;
        while (fire_cnt < target && c < budget) begin
            @(posedge clk);
            c++;
        end
        check(tag, 64'(fire_cnt >= target), 64'd1);
    endtask

    task automatic wait_idle(input int quiet, input int budget, input string tag);
        int run;
        int c;
        run = 0;
        c   = 0;
        while (run < quiet && c < budget) begin
            @(negedge clk);
            c++;
            if (ARVALID) run = 0;
            else run++;
        end
        check(tag, 64'(run >= quiet), 64'd1);
    endtask

    task automatic count_arvalid(input int cycles, output int hi);
        hi = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (ARVALID) hi++;
        end
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin : main_seq
        int f0;
        int f1;
        int w0;
        int hi;
        rst_n     = 1'b0;
        AXISTART  = 1'b0;
        DISPON    = 1'b1;
        VRAMADR   = '0;
        FIFOREADY = 1'b1;

        // Reset values and constant AXI fields
        repeat (3) @(posedge clk);
        #1;
        check("rst_arvalid", 64'(ARVALID), 64'd0);
        check("rst_rready",  64'(RREADY),  64'd0);
        check("rst_fifowr",  64'(FIFOWR),  64'd0);
        check("rst_rderr",   64'(RDERR),   64'd0);
        check("rst_araddr",  64'(ARADDR),  64'd0);
        check("arlen",   64'(ARLEN),   64'd15);
        check("arsize",  64'(ARSIZE),  64'd3);
        check("arburst", 64'(ARBURST), 64'd1);
        check("arcache", 64'(ARCACHE), 64'd3);
        check("arprot",  64'(ARPROT),  64'd0);
        check("arid",    64'(ARID),    64'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Frame A: uninterrupted full frame
        f0 = fire_cnt;
        w0 = wr_cnt;
        open_frame(32'h1000_0000);
        pulse_start(8);
        wait_idle(64, 20000, "frame_a_idle");
        check("frame_a_bursts", 64'(fire_cnt - f0), 64'(NB));
        check("frame_a_writes", 64'(wr_cnt - w0), 64'(NB * 16));
        check("frame_a_last_addr", 64'(last_addr), 64'h1000_3F80);
        check("frame_a_rderr", 64'(RDERR), 64'd0);

        // Frame B: ARREADY stall, FIFO back-pressure, restart at burst 100
        ar_stall = 7;
        f0 = fire_cnt;
        open_frame(32'h2000_0000);
        pulse_start(8);
        wait_fires(f0 + 1, 200, "stall_fire_timeout");
        check("ar_stall_cycles", 64'(arv_len), 64'd8);
        #1;
        ar_stall = 0;

        wait_fires(f0 + 4, 200, "burst3_timeout");
        #1;
        FIFOREADY = 1'b0;
        count_arvalid(60, hi);
        check("no_arvalid_fifo_full", 64'(hi), 64'd0);
        check("burst3_drained", 64'(exp_q.size()), 64'd0);
        FIFOREADY = 1'b1;
        wait_fires(f0 + 5, 50, "burst4_timeout");
        check("burst4_addr", 64'(last_addr), 64'h2000_0200);

        wait_fires(f0 + 101, 5000, "burst100_timeout");
        #1;
        check("rderr_before_err", 64'(RDERR), 64'd0);
        AXISTART = 1'b1;
        open_frame(32'h3000_0000);
        err_req++;
        repeat (12) @(posedge clk);
        #1;
        check("rderr_set", 64'(RDERR), 64'd1);
        check("b100_in_data", 64'(RREADY), 64'd1);
        AXISTART = 1'b0;
        f1 = fire_cnt;
        wait_fires(f1 + 1, 100, "restart_timeout");
        #1;
        check("restart_addr", 64'(last_addr), 64'h3000_0000);
        check("rderr_cleared", 64'(RDERR), 64'd0);
        wait_idle(64, 20000, "frame_c_idle");
        check("frame_c_bursts", 64'(fire_cnt - f1), 64'(NB));
        check("frame_c_last_addr", 64'(last_addr), 64'h3000_3F80);

        // Display disabled: start is ignored
        DISPON = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        pulse_start(10);
        count_arvalid(1000, hi);
        check("dispon_off_arvalid", 64'(hi), 64'd0);

        // Display enabled: start-to-ARVALID latency
        DISPON = 1'b1;
        open_frame(32'h4000_0000);
        f0 = fire_cnt;
        repeat (5) @(posedge clk);
        #1;
        AXISTART = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("arvalid_after_4_edges", 64'(ARVALID), 64'd0);
        @(posedge clk);
        #1;
        check("arvalid_after_5_edges", 64'(ARVALID), 64'd1);
        check("frame_d_first_addr", 64'(ARADDR), 64'h4000_0000);
        repeat (6) @(posedge clk);
        #1;
        AXISTART = 1'b0;

        // Error beat then asynchronous reset in the middle of a data phase
        wait_fires(f0 + 2, 200, "frame_d_timeout");
        #1;
        err_req++;
        repeat (10) @(posedge clk);
        #1;
        check("rderr_d_set", 64'(RDERR), 64'd1);
        check("d_in_data", 64'(RREADY), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_arvalid", 64'(ARVALID), 64'd0);
        check("arst_rready",  64'(RREADY),  64'd0);
        check("arst_fifowr",  64'(FIFOWR),  64'd0);
        check("arst_fifoin",  FIFOIN,       64'd0);
        check("arst_rderr",   64'(RDERR),   64'd0);
        check("arst_araddr",  64'(ARADDR),  64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        count_arvalid(200, hi);
        check("idle_after_reset", 64'(hi), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/disp_vramrd.md
# disp_vramrd

VRAM read master for the XGA display path. A frame-start request arrives from the pixel-clock display stage. The block then fetches one 1024×768 frame of 16-bit pixels from VRAM as fixed-length AXI4 read bursts. It pushes every returned 64-bit beat into the display FIFO, whose read side delivers 16-bit pixels to the display output stage.

## Interface
Parameters:
- HSIZE, 1024: active pixels per line.
- VSIZE, 768: active lines per frame.
- BURSTS, HSIZE*VSIZE*2/128 = 12288: 128-byte bursts per frame.

Ports:
- ACLK  in  1  AXI/VRAM clock; the only clock. Clock ports are named as the codebase does.
- ARESETN  in  1  Reset, asynchronous and active-low; also named as the codebase does.
- AXISTART  in  1  Frame-start level pulse (one line period or longer) from the pixel domain; asynchronous to ACLK.
- DISPON  in  1  Display enable level from the pixel domain; asynchronous to ACLK.
- VRAMADR  in  32  Frame base byte address; 128-byte aligned; sampled at frame start.
- FIFOREADY  in  1  At least 16 free 64-bit entries are available on the FIFO write side.
- FIFOWR  out  1  FIFO write strobe.
- FIFOIN  out  64  FIFO write data.
- ARADDR  out  32  AXI read address.
- ARLEN  out  8  Constant 8'd15.
- ARSIZE  out  3  Constant 3'b011.
- ARBURST  out  2  Constant 2'b01.
- ARCACHE  out  4  Constant 4'b0011.
- ARPROT  out  3  Constant 3'b000.
- ARID  out  1  Constant 0.
- ARVALID  out  1  AXI read address valid.
- ARREADY  in  1  AXI read address ready.
- RDATA  in  64  AXI read data.
- RRESP  in  2  AXI read response.
- RLAST  in  1  AXI last beat of burst.
- RVALID  in  1  AXI read data valid.
- RREADY  out  1  AXI read data ready.
- RDERR  out  1  Sticky flag: an RRESP[1]=1 beat was seen. Cleared at the next frame start.

## Operation
- Synchronisers:
  - AXISTART and DISPON each pass through 2 flops (start_s, dispon_s).
  - A third flop on start_s gives a registered rising-edge pulse, start_p.
- Burst counter: 14 bits, 0..BURSTS-1.
- Address: ARADDR = base_q + {cnt, 7'b0}.
  - base_q is loaded from VRAMADR whenever cnt is reset to 0 by a frame start.
- State machine, states IDLE, WAITF, ADDR, DATA:
  - IDLE: on start_p & dispon_s, load base_q, cnt=0, clear RDERR, go to WAITF. start_p with dispon_s=0 is ignored.
  - WAITF: go to ADDR when FIFOREADY=1.
  - ADDR: ARVALID=1. ARADDR is held stable until ARVALID&ARREADY, then go to DATA. ARVALID never drops without a handshake.
  - DATA: RREADY=1. On each RVALID&RREADY beat, FIFOWR=1 and FIFOIN=RDATA in the same cycle (combinational pass-through). On the RLAST beat:
    - restart flag set: cnt=0, reload base_q, clear flag and RDERR; go to WAITF if dispon_s, else IDLE.
    - else if cnt==BURSTS-1: go to IDLE.
    - else: cnt+1, go to WAITF.
- Restart: start_p in WAITF, ADDR or DATA sets the restart flag (underrun case). The outstanding burst always completes, so AXI is never violated.
  - In WAITF the restart is taken immediately: cnt=0 and base_q reloaded, staying in WAITF.
- Data accepted without RLAST is written normally.
- RRESP errors do not stop the frame. Data is still written and RDERR is set.

## Timing
- Reset values: ARVALID=0, RREADY=0, FIFOWR=0, RDERR=0, ARADDR=0, state IDLE, cnt=0, restart flag=0. Constant AXI fields are fixed at all times.
- ARESETN asserted mid-burst: immediate return to reset values. The interconnect shares the same reset.
- AXISTART rises before ACLK edge N:
  - start_p is high in cycle N+3.
  - State is WAITF in N+4.
  - With FIFOREADY=1, ARVALID is first high in cycle N+5.
- ARVALID&ARREADY at edge M: RREADY=1 from cycle M+1.
- RLAST accepted at edge K: ARVALID for the next burst is earliest in cycle K+2 (WAITF, then ADDR).
- Exactly one burst is outstanding at any time. RREADY is only high in DATA, where FIFO space is guaranteed.
- One frame: exactly 12288 AR handshakes and 196608 FIFOWR pulses.

## Test plan
- Full frame, VRAMADR=32'h1000_0000, ARREADY/RVALID always 1, FIFOREADY=1:
  - 12288 bursts, ARADDR 0x1000_0000..0x1017_FF80 in steps of 0x80.
  - 196608 FIFOWR pulses; returns to IDLE.
- ARREADY held low for 7 cycles: ARVALID stays 1 and ARADDR is unchanged throughout; the handshake occurs on the 8th cycle.
- FIFOREADY=0 for 50 cycles after burst 3: no ARVALID during that window; burst 4 ARADDR = base+0x200 once FIFOREADY returns.
- AXISTART pulsed during burst 100 DATA phase:
  - burst 100 completes all 16 beats;
  - the next ARADDR equals the newly sampled VRAMADR; RDERR is cleared.
- DISPON=0 with an AXISTART pulse: no ARVALID for 1000 cycles. Then set DISPON=1 and pulse AXISTART: ARVALID rises 5 cycles after the AXISTART edge.
- RRESP=2'b10 on one beat: RDERR=1 and the beat is still written. ARESETN pulsed low mid-DATA: all outputs return to 0 asynchronously and the state is IDLE.
